// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/JALR resolver: checks the outcome against the front-end
// prediction, issues a registered redirect, then a fixed-length flush; counts taken/mispredicts.
module branch_resolve_unit #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_i,
   input  logic             stall_i,
   input  logic [2:0]       br_type_i,
   input  logic             pred_taken_i,
   input  logic [XLEN-1:0]  pc_i,
   input  logic [XLEN-1:0]  imm_i,
   input  logic [XLEN-1:0]  rs1_val_i,
   input  logic [XLEN-1:0]  rs2_val_i,
   input  logic [1:0]       fwd_a_sel_i,
   input  logic [1:0]       fwd_b_sel_i,
   input  logic [XLEN-1:0]  mem_fwd_i,
   input  logic [XLEN-1:0]  wb_fwd_i,
   output logic             redirect_o,
   output logic [XLEN-1:0]  redirect_pc_o,
   output logic             flush_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] taken_cnt_o,
   output logic [CNT_W-1:0] mispred_cnt_o
);

   localparam int unsigned FC_W = 4;

   localparam logic [2:0] BR_NONE = 3'd0;
   localparam logic [2:0] BR_BEQ  = 3'd1;
   localparam logic [2:0] BR_BNE  = 3'd2;
   localparam logic [2:0] BR_BLT  = 3'd3;
   localparam logic [2:0] BR_BGE  = 3'd4;
   localparam logic [2:0] BR_BLTU = 3'd5;
   localparam logic [2:0] BR_BGEU = 3'd6;
   localparam logic [2:0] BR_JALR = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_FLUSH} state_t;

   state_t            r_state;
   logic [FC_W-1:0]   r_flush_cnt;
   logic              r_redirect;
   logic              r_flush;
   logic              r_busy;
   logic [XLEN-1:0]   r_redirect_pc;
   logic [CNT_W-1:0]  r_taken_cnt;
   logic [CNT_W-1:0]  r_mispred_cnt;

   logic [XLEN-1:0]   w_a;
   logic [XLEN-1:0]   w_b;
   logic              w_taken;
   logic [XLEN-1:0]   w_br_tgt;
   logic [XLEN-1:0]   w_jalr_tgt;
   logic [XLEN-1:0]   w_fall;
   logic [XLEN-1:0]   w_target;
   logic              w_resolve;
   logic              w_mispred;

   // Operand forwarding; the reserved select falls back to the decode value
   always_comb begin
      w_a = rs1_val_i;
      w_b = rs2_val_i;
      case (fwd_a_sel_i)
         2'd1:    w_a = mem_fwd_i;
         2'd2:    w_a = wb_fwd_i;
         default: w_a = rs1_val_i;
      endcase
      case (fwd_b_sel_i)
         2'd1:    w_b = mem_fwd_i;
         2'd2:    w_b = wb_fwd_i;
         default: w_b = rs2_val_i;
      endcase
   end

   always_comb begin
      w_taken = 1'b0;
      case (br_type_i)
         BR_BEQ:  w_taken = (w_a == w_b);
         BR_BNE:  w_taken = (w_a != w_b);
         BR_BLT:  w_taken = ($signed(w_a) <  $signed(w_b));
         BR_BGE:  w_taken = ($signed(w_a) >= $signed(w_b));
         BR_BLTU: w_taken = (w_a <  w_b);
         BR_BGEU: w_taken = (w_a >= w_b);
         BR_JALR: w_taken = 1'b1;
         default: w_taken = 1'b0;
      endcase
   end

   assign w_br_tgt   = pc_i + imm_i;
   assign w_jalr_tgt = (w_a + imm_i) & ~XLEN'(1);
   assign w_fall     = pc_i + XLEN'(4);
   assign w_target   = !w_taken                ? w_fall     :
                       (br_type_i == BR_JALR)  ? w_jalr_tgt : w_br_tgt;

   assign w_resolve = valid_i && !stall_i && (br_type_i != BR_NONE) && (r_state == S_IDLE);
   assign w_mispred = w_resolve && (w_taken != pred_taken_i);

   // Redirect/flush sequencer; stall does not pause an in-flight flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_flush_cnt   <= '0;
         r_redirect    <= 1'b0;
         r_flush       <= 1'b0;
         r_busy        <= 1'b0;
         r_redirect_pc <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_mispred) begin
                  r_state       <= S_REDIRECT;
                  r_redirect    <= 1'b1;
                  r_flush       <= 1'b1;
                  r_busy        <= 1'b1;
                  r_redirect_pc <= w_target;
               end
            end
            S_REDIRECT: begin
               r_state     <= S_FLUSH;
               r_redirect  <= 1'b0;
               r_flush_cnt <= FC_W'(FLUSH_CYCLES);
            end
            S_FLUSH: begin
               if (r_flush_cnt == FC_W'(1)) begin
                  r_state <= S_IDLE;
                  r_flush <= 1'b0;
                  r_busy  <= 1'b0;
               end else begin
                  r_flush_cnt <= r_flush_cnt - FC_W'(1);
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_redirect <= 1'b0;
               r_flush    <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_taken_cnt   <= '0;
         r_mispred_cnt <= '0;
      end else begin
         if (w_resolve && w_taken && (r_taken_cnt != '1))
            r_taken_cnt <= r_taken_cnt + CNT_W'(1);
         if (w_mispred && (r_mispred_cnt != '1))
            r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end
   end

   assign redirect_o    = r_redirect;
   assign redirect_pc_o = r_redirect_pc;
   assign flush_o       = r_flush;
   assign busy_o        = r_busy;
   assign taken_cnt_o   = r_taken_cnt;
   assign mispred_cnt_o = r_mispred_cnt;

endmodule
